// File: rtl/mul_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_ctrl_pkg
// Brief    : Shared types, defaults and batch-size helper for mul_stream_ctrl
// Revision : 1.0 - initial release
// ============================================================================
package mul_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 4;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    // A zero or oversized batch request means "fill the whole FIFO".
    function automatic int norm_batch(input int batch, input int depth);
        return ((batch == 0) || (batch > depth)) ? depth : batch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_ctrl_drain.sv
`default_nettype none
// ============================================================================
// Module   : mul_ctrl_drain
// Brief    : Result-FIFO reader with a 2-entry skid feeding a valid/ready port
// Revision : 1.0 - initial release
// ============================================================================
module mul_ctrl_drain #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic [CNT_W-1:0]  i_res_cnt,
    input  logic [DATA_W-1:0] i_res_dout,
    input  logic              i_out_ready,
    output logic              o_res_re,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_idle
);

    logic [DATA_W-1:0] r_skid [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic              r_pend;
    logic [1:0]        r_fill;

    logic              w_pop;
    logic [2:0]        w_occ;

    assign o_out_valid = (r_fill != 2'd0) && !i_flush;
    assign o_out_data  = r_skid[r_rd_ptr];
    assign w_pop       = o_out_valid && i_out_ready;

    // Occupancy after this edge, counting the read already in flight.
    assign w_occ    = {1'b0, r_fill} + {2'b00, r_pend} - {2'b00, w_pop};
    assign o_res_re = i_en && !i_flush && (i_res_cnt != '0) && (w_occ < 3'd2);
    assign o_idle   = (i_res_cnt == '0) && !r_pend && (r_fill == 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid[0] <= '0;
            r_skid[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_pend    <= 1'b0;
            r_fill    <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_pend    <= 1'b0;
            r_fill    <= 2'd0;
        end else begin
            r_pend <= o_res_re;
            if (r_pend) begin
                r_skid[r_wr_ptr] <= i_res_dout;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_fill <= w_occ[1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_stream_ctrl
// Brief    : Streams operand pairs into the multiplier FIFOs, runs the
//            start/done/clear handshake and drains results to a stream.
//            Optional sticky error checks: define MUL_CTRL_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mul_stream_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_sw_clear,
    input  logic [CNT_W-1:0]  i_cfg_batch,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_a,
    input  logic [DATA_W-1:0] i_in_b,
    input  logic              i_in_last,
    output logic              o_op_we,
    output logic [DATA_W-1:0] o_op_din0,
    output logic [DATA_W-1:0] o_op_din1,
    input  logic [CNT_W-1:0]  i_op_cnt0,
    input  logic [CNT_W-1:0]  i_op_cnt1,
    output logic              o_multi_opstart,
    output logic              o_multi_opclear,
    input  logic              i_multi_opdone,
    output logic              o_res_re,
    input  logic [DATA_W-1:0] i_res_dout,
    input  logic [CNT_W-1:0]  i_res_cnt,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_busy,
    output logic              o_err
);

    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_pair_cnt;
    logic             r_opstart;
    logic             r_opclear;

    logic [CNT_W-1:0] w_batch;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_close;
    logic             w_run_exit;
    logic             w_drain_idle;

    assign w_batch = CNT_W'(norm_batch(int'(i_cfg_batch), DEPTH));

    // sw_clear wins over a beat, so the beat is refused rather than dropped.
    assign w_in_ready = !reset && !i_sw_clear
                     && ((r_state == ST_IDLE) || (r_state == ST_LOAD))
                     && (i_op_cnt0 < c_DEPTH) && (i_op_cnt1 < c_DEPTH)
                     && (r_pair_cnt < w_batch);
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_close    = w_accept && (i_in_last || ((r_pair_cnt + 1'b1) >= w_batch));
    assign w_run_exit = i_multi_opdone && (i_op_cnt0 == '0) && (i_op_cnt1 == '0);

    assign o_in_ready      = w_in_ready;
    assign o_op_we         = w_accept;
    assign o_op_din0       = w_accept ? i_in_a : '0;
    assign o_op_din1       = w_accept ? i_in_b : '0;
    assign o_multi_opstart = r_opstart;
    assign o_multi_opclear = r_opclear;
    assign o_busy          = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pair_cnt <= '0;
            r_opstart  <= 1'b0;
            r_opclear  <= 1'b0;
        end else begin
            r_opclear <= 1'b0;
            if (i_sw_clear) begin
                r_state    <= ST_CLEAR;
                r_pair_cnt <= '0;
                r_opstart  <= 1'b0;
                r_opclear  <= 1'b1;
            end else begin
                if (w_accept && (r_pair_cnt < c_DEPTH)) begin
                    r_pair_cnt <= r_pair_cnt + 1'b1;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_state   <= w_close ? ST_RUN : ST_LOAD;
                            r_opstart <= w_close;
                        end
                    end
                    ST_LOAD: begin
                        if (w_close || (r_pair_cnt >= w_batch)) begin
                            r_state   <= ST_RUN;
                            r_opstart <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_run_exit) begin
                            r_state   <= ST_DRAIN;
                            r_opstart <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_drain_idle) begin
                            r_state   <= ST_CLEAR;
                            r_opclear <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        r_state    <= ST_IDLE;
                        r_pair_cnt <= '0;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_opstart <= 1'b0;
                    end
                endcase
            end
        end
    end

    mul_ctrl_drain #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_drain (
        .clk         (clk),
        .reset       (reset),
        .i_en        (r_state == ST_DRAIN),
        .i_flush     (i_sw_clear),
        .i_res_cnt   (i_res_cnt),
        .i_res_dout  (i_res_dout),
        .i_out_ready (i_out_ready),
        .o_res_re    (o_res_re),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .o_idle      (w_drain_idle)
    );

`ifdef MUL_CTRL_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (i_sw_clear) begin
            r_err <= 1'b0;
        end else if ((i_multi_opdone && (r_state != ST_RUN))
                  || ((r_state == ST_RUN) && w_run_exit && (i_res_cnt != r_pair_cnt))
                  || (w_accept && ((i_op_cnt0 == c_DEPTH) || (i_op_cnt1 == c_DEPTH)))) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_stream_ctrl
// Brief    : Directed, table-driven bench for mul_stream_ctrl with a small
//            behavioural model of the FIFO/multiplier cluster
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_stream_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int TMO   = 200;

`ifdef MUL_CTRL_ERR_EN
    localparam logic c_ERR_EXP = 1'b1;
`else
    localparam logic c_ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sw_clear = 1'b0;
    logic [CW-1:0] cfg_batch = CW'(4);
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          in_last = 1'b0;
    logic          op_we;
    logic [DW-1:0] op_din0, op_din1;
    logic [CW-1:0] op_cnt0, op_cnt1;
    logic          opstart, opclear, mul_done;
    logic          res_re;
    logic [DW-1:0] res_dout;
    logic [CW-1:0] res_cnt;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          busy, err;

    always #5 clk = ~clk;

    mul_stream_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .i_sw_clear(sw_clear), .i_cfg_batch(cfg_batch),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_a(in_a), .i_in_b(in_b),
        .i_in_last(in_last), .o_op_we(op_we), .o_op_din0(op_din0), .o_op_din1(op_din1),
        .i_op_cnt0(op_cnt0), .i_op_cnt1(op_cnt1), .o_multi_opstart(opstart),
        .o_multi_opclear(opclear), .i_multi_opdone(mul_done), .o_res_re(res_re),
        .i_res_dout(res_dout), .i_res_cnt(res_cnt), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_data(out_data), .o_busy(busy), .o_err(err)
    );

    // ---------------- cluster model: operand FIFOs, multiplier, result FIFO
    logic [DW-1:0] opq_a[$], opq_b[$], resq[$];
    logic [CW-1:0] env_cnt = '0, env_res_cnt = '0;
    logic [DW-1:0] env_dout = '0;
    logic          env_done = 1'b0;
    bit            done_sent = 0;
    logic          force_en = 1'b0;
    logic [CW-1:0] force_val = '0;
    logic          done_force = 1'b0;
    logic          mul_stall = 1'b0;
    int            overread = 0, stall_viol = 0, skid_viol = 0, we_cnt = 0, clr_cnt = 0;

    assign op_cnt0  = force_en ? force_val : env_cnt;
    assign op_cnt1  = env_cnt;
    assign res_cnt  = env_res_cnt;
    assign res_dout = env_dout;
    assign mul_done = env_done | done_force;

    always @(posedge clk or posedge reset) begin
        logic [DW-1:0] x, y, p;
        bit fire;
        if (reset) begin
            opq_a.delete(); opq_b.delete(); resq.delete();
            done_sent = 0;
            env_cnt <= '0; env_res_cnt <= '0; env_dout <= '0; env_done <= 1'b0;
        end else if (opclear) begin
            opq_a.delete(); opq_b.delete(); resq.delete();
            done_sent = 0;
            env_cnt <= '0; env_res_cnt <= '0; env_done <= 1'b0;
        end else begin
            if (op_we) begin
                opq_a.push_back(op_din0); opq_b.push_back(op_din1); we_cnt++;
            end
            if (opstart && !mul_stall && opq_a.size() > 0) begin
                x = opq_a.pop_front(); y = opq_b.pop_front(); p = x * y;
                resq.push_back(p);
            end
            if (res_re) begin
                if (resq.size() == 0) overread++;
                else env_dout <= resq.pop_front();
            end
            fire = opstart && !mul_stall && (opq_a.size() == 0) && !done_sent;
            if (fire) done_sent = 1;
            env_done    <= fire;
            env_cnt     <= CW'(opq_a.size());
            env_res_cnt <= CW'(resq.size());
        end
    end

    // ---------------- output monitor
    logic [DW-1:0] got[$];
    bit            held = 0;
    logic [DW-1:0] held_data = '0;

    always @(posedge clk) begin
        if (reset) begin
            held = 0;
        end else begin
            if (opclear) clr_cnt++;
            if (held && !sw_clear && !(out_valid && out_data == held_data)) stall_viol++;
            held      = out_valid && !out_ready;
            held_data = out_data;
            if (out_valid && out_ready) got.push_back(out_data);
            if (dut.u_drain.r_fill > 2'd2) skid_viol++;
        end
    end

    // ---------------- out_ready driver: 0 = low, 1 = high, 2 = 1,0,0 pattern
    int rdy_mode = 0;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       out_ready = 1'b1;
                2:       out_ready = (ph == 0);
                default: out_ready = 1'b0;
            endcase
            ph = (ph == 2) ? 0 : ph + 1;
        end
    end

    // ---------------- checking
    int passed = 0, total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          last;
        logic [DW-1:0] prod;
    } vec_t;

    vec_t vecs[12];

    task automatic send_beat(input int idx);
        bit acc;
        acc = 0;
        in_valid = 1'b1; in_a = vecs[idx].a; in_b = vecs[idx].b; in_last = vecs[idx].last;
        for (int c = 0; c < TMO && !acc; c++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!acc) check($sformatf("accept_timeout_v%0d", idx), 0, 1);
    endtask

    task automatic drain_and_check(input int first, input int n, input string tag);
        int c;
        c = 0;
        while ((got.size() < n || busy) && c < TMO * 4) begin
            @(posedge clk); #1; c++;
        end
        check({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            check($sformatf("%s_out%0d", tag, i), got[i], vecs[first + i].prod);
        check({tag, "_idle"}, busy, 1'b0);
        got.delete();
    endtask

    task automatic wait_out_valid(input string tag);
        bit seen;
        seen = 0;
        for (int c = 0; c < TMO && !seen; c++) begin
            @(negedge clk); seen = out_valid;
        end
        if (!seen) check({tag, "_valid_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int we0, clr0;

        vecs[0]  = '{32'd3,     32'd5,          1'b0, 32'd15};
        vecs[1]  = '{32'd7,     32'd9,          1'b0, 32'd63};
        vecs[2]  = '{32'd0,     32'hFFFF_FFFF,  1'b0, 32'd0};
        vecs[3]  = '{32'd65535, 32'd65537,      1'b0, 32'hFFFF_FFFF};
        vecs[4]  = '{32'd12,    32'd11,         1'b0, 32'd132};
        vecs[5]  = '{32'd100,   32'd1000,       1'b1, 32'd100000};
        vecs[6]  = '{32'd2,     32'd3,          1'b0, 32'd6};
        vecs[7]  = '{32'd4,     32'd5,          1'b0, 32'd20};
        vecs[8]  = '{32'd6,     32'd7,          1'b0, 32'd42};
        vecs[9]  = '{32'd8,     32'd9,          1'b0, 32'd72};
        vecs[10] = '{32'd10,    32'd11,         1'b0, 32'd110};
        vecs[11] = '{32'd123,   32'd456,        1'b0, 32'd56088};

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_op_we", op_we, 0);
        check("rst_opstart", opstart, 0);
        check("rst_opclear", opclear, 0);
        check("rst_res_re", res_re, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // 1: batch of 4, out_ready high
        rdy_mode = 1; cfg_batch = CW'(4);
        @(posedge clk); #1;
        we0 = we_cnt; clr0 = clr_cnt;
        for (int i = 0; i < 4; i++) send_beat(i);
        check("t1_ready_low_in_run", in_ready, 0);
        check("t1_opstart_in_run", opstart, 1);
        drain_and_check(0, 4, "t1");
        check("t1_we_pulses", we_cnt - we0, 4);
        check("t1_clear_pulses", clr_cnt - clr0, 1);

        // 2: batch 8 closed early by in_last
        cfg_batch = CW'(8);
        we0 = we_cnt; clr0 = clr_cnt;
        send_beat(4);
        send_beat(5);
        check("t2_run_after_last", opstart, 1);
        check("t2_we_pulses", we_cnt - we0, 2);
        drain_and_check(4, 2, "t2");
        check("t2_pair_cnt_zero", dut.r_pair_cnt, 0);
        check("t2_clear_pulses", clr_cnt - clr0, 1);

        // 3: drain under back-pressure
        cfg_batch = CW'(6); rdy_mode = 2;
        for (int i = 6; i < 12; i++) send_beat(i);
        drain_and_check(6, 6, "t3");
        check("t3_stall_stable", stall_viol, 0);
        check("t3_skid_le2", skid_viol, 0);
        check("t3_no_overread", overread, 0);

        // 4: operand FIFO0 full during LOAD
        rdy_mode = 1; cfg_batch = CW'(4);
        send_beat(0);
        in_valid = 1'b1; in_a = vecs[1].a; in_b = vecs[1].b;
        force_en = 1'b1; force_val = CW'(8);
        @(negedge clk);
        check("t4_full_ready", in_ready, 0);
        check("t4_full_we", op_we, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_full_ready2", in_ready, 0);
        @(posedge clk); #1;
        force_val = CW'(7);
        @(negedge clk);
        check("t4_resume_ready", in_ready, 1);
        check("t4_resume_we", op_we, 1);
        @(posedge clk); #1;
        force_en = 1'b0; in_valid = 1'b0;
        send_beat(2);
        send_beat(3);
        drain_and_check(0, 4, "t4");
        check("t4_err_clean", err, 0);

        // 5a: sw_clear while RUN
        cfg_batch = CW'(2); mul_stall = 1'b1;
        clr0 = clr_cnt;
        send_beat(0);
        send_beat(1);
        check("t5a_in_run", opstart, 1);
        repeat (3) begin @(posedge clk); #1; end
        sw_clear = 1'b1;
        @(negedge clk);
        check("t5a_ready_on_clear", in_ready, 0);
        @(posedge clk); #1;
        sw_clear = 1'b0;
        check("t5a_clear_pulse", opclear, 1);
        check("t5a_opstart_drop", opstart, 0);
        @(posedge clk); #1;
        check("t5a_clear_one_cycle", opclear, 0);
        check("t5a_idle", busy, 0);
        check("t5a_clear_count", clr_cnt - clr0, 1);
        mul_stall = 1'b0;

        // 5b: sw_clear while DRAIN with a full skid
        cfg_batch = CW'(3); rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_beat(i);
        wait_out_valid("t5b");
        sw_clear = 1'b1;
        #1;
        check("t5b_valid_drop", out_valid, 0);
        check("t5b_res_re_drop", res_re, 0);
        @(posedge clk); #1;
        sw_clear = 1'b0;
        check("t5b_clear_pulse", opclear, 1);
        check("t5b_skid_flushed", out_valid, 0);
        @(posedge clk); #1;
        check("t5b_idle", busy, 0);
        check("t5b_no_output", got.size(), 0);
        got.delete();

        // 5c: asynchronous reset while DRAIN
        for (int i = 0; i < 3; i++) send_beat(i);
        wait_out_valid("t5c");
        #2 reset = 1'b1;
        #1;
        check("t5c_out_valid", out_valid, 0);
        check("t5c_out_data", out_data, 0);
        check("t5c_res_re", res_re, 0);
        check("t5c_busy", busy, 0);
        check("t5c_opstart", opstart, 0);
        check("t5c_opclear", opclear, 0);
        check("t5c_in_ready", in_ready, 0);
        @(negedge clk); reset = 1'b0;
        got.delete();
        @(posedge clk); #1;

        // 6: stray multi_opdone in IDLE
        rdy_mode = 1;
        done_force = 1'b1;
        @(posedge clk); #1;
        done_force = 1'b0;
        check("t6_err_set", err, c_ERR_EXP);
        check("t6_still_idle", busy, 0);
        repeat (3) begin @(posedge clk); #1; end
        check("t6_err_sticky", err, c_ERR_EXP);
        sw_clear = 1'b1;
        @(posedge clk); #1;
        sw_clear = 1'b0;
        check("t6_err_cleared", err, 0);
        @(posedge clk); #1;
        check("t6_back_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
